aes128_bus_regs: RTL and testbench

- Memory-mapped register front end that sits directly upstream of the AES-128 engine FSM.
- Collects the 128-bit key and data from 32-bit CPU writes and issues a single-cycle start with op to the engine.
- Captures the engine's 128-bit result and exposes status, a busy-cycle counter and a level interrupt.

---
 rtl/aes128_type_pkg.sv | 41 ++++
 rtl/aes128_op_sequencer.sv | 100 ++++++++++
 rtl/aes128_bus_regs.sv | 115 +++++++++++
 tb/tb_aes128_bus_regs.sv | 343 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes128_type_pkg.sv
// Register map, CTRL/STATUS field positions, OP mode and sequencer state types
// shared by the AES-128 bus register front end and its operation sequencer.
package aes128_type_pkg;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned BLK_W  = 128;

  localparam logic [ADDR_W-1:0] ADDR_KEY0    = 4'd0;
  localparam logic [ADDR_W-1:0] ADDR_DATA0   = 4'd4;
  localparam logic [ADDR_W-1:0] ADDR_DATA3   = 4'd7;
  localparam logic [ADDR_W-1:0] ADDR_RESULT0 = 4'd8;
  localparam logic [ADDR_W-1:0] ADDR_CTRL    = 4'd12;
  localparam logic [ADDR_W-1:0] ADDR_STATUS  = 4'd13;
  localparam logic [ADDR_W-1:0] ADDR_CYCLES  = 4'd14;

  localparam int unsigned CTRL_START   = 0;
  localparam int unsigned CTRL_OP_LSB  = 1;
  localparam int unsigned CTRL_CLR_ERR = 3;
  localparam int unsigned CTRL_IRQ_ACK = 4;

  localparam int unsigned ST_IDLE   = 0;
  localparam int unsigned ST_DONE   = 1;
  localparam int unsigned ST_ERR    = 2;
  localparam int unsigned ST_OP_LSB = 3;

  typedef enum logic [1:0] {
    MODE_ENC  = 2'd0,
    MODE_DEC  = 2'd1,
    MODE_RSV2 = 2'd2,
    MODE_RSV3 = 2'd3
  } mode_t;

  typedef enum logic [1:0] {
    SEQ_IDLE = 2'd0,
    SEQ_PEND = 2'd1,
    SEQ_BUSY = 2'd2,
    SEQ_DONE = 2'd3
  } seq_state_t;

endpackage

// File: rtl/aes128_op_sequencer.sv
// Operation sequencer: IDLE/PEND/BUSY/DONE FSM, engine start pulse, result-valid
// rising-edge detect, sticky err, level irq and saturating busy-cycle counter.
module aes128_op_sequencer
  import aes128_type_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_req,
  input  logic             clr_err,
  input  logic             irq_ack,
  input  logic             aes_ready_i,
  input  logic             aes_valid_i,
  output logic             aes_start_o,
  output logic             irq_o,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] cycles,
  output logic             idle_c,
  output logic             capture_c
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  seq_state_t       state_q, state_d;
  logic             valid_q, valid_d;
  logic             start_d, done_d, err_d, irq_d;
  logic [CNT_W-1:0] cycles_d;

  // State and registered outputs
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= SEQ_IDLE;
      valid_q     <= 1'b0;
      aes_start_o <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      irq_o       <= 1'b0;
      cycles      <= '0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      aes_start_o <= start_d;
      done        <= done_d;
      err         <= err_d;
      irq_o       <= irq_d;
      cycles      <= cycles_d;
    end
  end

  // Next state; later assignments take priority (start clears, done sets irq over ack)
  always_comb begin
    state_d   = state_q;
    valid_d   = aes_valid_i;
    start_d   = 1'b0;
    done_d    = done;
    err_d     = err;
    irq_d     = irq_o;
    cycles_d  = cycles;
    capture_c = 1'b0;

    if (clr_err) err_d = 1'b0;
    if (irq_ack) irq_d = 1'b0;
    if ((state_q == SEQ_PEND || state_q == SEQ_BUSY) && cycles != CNT_MAX)
      cycles_d = cycles + CNT_W'(1);

    case (state_q)
      SEQ_IDLE, SEQ_DONE: begin
        if (start_req) begin
          state_d  = SEQ_PEND;
          done_d   = 1'b0;
          cycles_d = '0;
        end
      end
      SEQ_PEND: begin
        if (start_req) err_d = 1'b1;
        if (aes_ready_i) begin
          state_d = SEQ_BUSY;
          start_d = 1'b1;
          // A stale valid from the previous op must not look like a rising edge
          valid_d = 1'b1;
        end
      end
      SEQ_BUSY: begin
        if (start_req) err_d = 1'b1;
        if (!valid_q && aes_valid_i) begin
          state_d   = SEQ_DONE;
          done_d    = 1'b1;
          irq_d     = 1'b1;
          capture_c = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  assign idle_c = (state_q == SEQ_IDLE) || (state_q == SEQ_DONE);

endmodule

// File: rtl/aes128_bus_regs.sv
// CPU register front end for the AES-128 engine: key/data/result words, CTRL/STATUS/CYCLES.
// Build option AES128_AUTO_START_EN: a DATA3 write in IDLE/DONE starts with the latched OP.
module aes128_bus_regs
  import aes128_type_pkg::*;
#(
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [ADDR_W-1:0]  addr_i,
  input  logic [WORD_W-1:0]  wdata_i,
  input  logic               we_i,
  input  logic               re_i,
  output logic [WORD_W-1:0]  rdata_o,
  output logic               rvalid_o,
  output logic               irq_o,
  output logic               aes_start_o,
  output logic [1:0]         aes_op_o,
  output logic [BLK_W-1:0]   aes_key_o,
  output logic [BLK_W-1:0]   aes_data_o,
  input  logic [BLK_W-1:0]   aes_result_i,
  input  logic               aes_valid_i,
  input  logic               aes_ready_i
);

  logic [WORD_W-1:0] key_q  [4];
  logic [WORD_W-1:0] data_q [4];
  logic [WORD_W-1:0] res_q  [4];
  mode_t             op_q;

  logic              ctrl_wr_c, data3_wr_c, start_req_c, capture_c, idle_c;
  logic              done, err;
  logic [CNT_W-1:0]  cycles;
  logic [WORD_W-1:0] status_c, rdata_c;

  assign ctrl_wr_c = we_i && (addr_i == ADDR_CTRL);
`ifdef AES128_AUTO_START_EN
  assign data3_wr_c = we_i && (addr_i == ADDR_DATA3);
`else
  assign data3_wr_c = 1'b0;
`endif
  assign start_req_c = (ctrl_wr_c && wdata_i[CTRL_START]) || data3_wr_c;

  aes128_op_sequencer #(.CNT_W(CNT_W)) u_seq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .start_req   (start_req_c),
    .clr_err     (ctrl_wr_c && wdata_i[CTRL_CLR_ERR]),
    .irq_ack     (ctrl_wr_c && wdata_i[CTRL_IRQ_ACK]),
    .aes_ready_i (aes_ready_i),
    .aes_valid_i (aes_valid_i),
    .aes_start_o (aes_start_o),
    .irq_o       (irq_o),
    .done        (done),
    .err         (err),
    .cycles      (cycles),
    .idle_c      (idle_c),
    .capture_c   (capture_c)
  );

  // Register file; KEY/DATA writable in every state, RESULT loaded only by the engine
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < 4; i++) begin
        key_q[i]  <= '0;
        data_q[i] <= '0;
        res_q[i]  <= '0;
      end
      op_q <= MODE_ENC;
    end else begin
      if (we_i && addr_i[3:2] == ADDR_KEY0[3:2])  key_q[addr_i[1:0]]  <= wdata_i;
      if (we_i && addr_i[3:2] == ADDR_DATA0[3:2]) data_q[addr_i[1:0]] <= wdata_i;
      if (ctrl_wr_c) op_q <= mode_t'(wdata_i[CTRL_OP_LSB +: 2]);
      if (capture_c) begin
        res_q[0] <= aes_result_i[127:96];
        res_q[1] <= aes_result_i[95:64];
        res_q[2] <= aes_result_i[63:32];
        res_q[3] <= aes_result_i[31:0];
      end
    end
  end

  always_comb begin
    status_c                  = '0;
    status_c[ST_IDLE]         = idle_c;
    status_c[ST_DONE]         = done;
    status_c[ST_ERR]          = err;
    status_c[ST_OP_LSB +: 2]  = op_q;
  end

  // Read mux sees pre-write register values, so a same-cycle write+read returns old data
  always_comb begin
    rdata_c = '0;
    if (addr_i[3:2] == ADDR_KEY0[3:2])         rdata_c = key_q[addr_i[1:0]];
    else if (addr_i[3:2] == ADDR_DATA0[3:2])   rdata_c = data_q[addr_i[1:0]];
    else if (addr_i[3:2] == ADDR_RESULT0[3:2]) rdata_c = res_q[addr_i[1:0]];
    else if (addr_i == ADDR_STATUS)            rdata_c = status_c;
    else if (addr_i == ADDR_CYCLES)            rdata_c = WORD_W'(cycles);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rdata_o  <= '0;
      rvalid_o <= 1'b0;
    end else begin
      rvalid_o <= re_i;
      if (re_i) rdata_o <= rdata_c;
    end
  end

  assign aes_op_o   = op_q;
  assign aes_key_o  = {key_q[0], key_q[1], key_q[2], key_q[3]};
  assign aes_data_o = {data_q[0], data_q[1], data_q[2], data_q[3]};

endmodule

// File: tb/tb_aes128_bus_regs.sv
// Bench for aes128_bus_regs: engine stub with programmable latency/ready, register-level
// reference model, directed FIPS-197 cases plus randomized register traffic and operations.
module tb_aes128_bus_regs;

  localparam logic [127:0] FIPS_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FIPS_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FIPS_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [3:0] A_CTRL = 4'd12, A_STATUS = 4'd13, A_CYCLES = 4'd14;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [3:0] addr = '0;
  logic [31:0] wdata = '0, rdata;
  logic we = 1'b0, re = 1'b0;
  logic rvalid, irq, aes_start, aes_valid, aes_ready;
  logic [1:0] aes_op;
  logic [127:0] aes_key, aes_data, aes_result;

  aes128_bus_regs #(.CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .addr_i(addr), .wdata_i(wdata), .we_i(we), .re_i(re),
    .rdata_o(rdata), .rvalid_o(rvalid), .irq_o(irq), .aes_start_o(aes_start),
    .aes_op_o(aes_op), .aes_key_o(aes_key), .aes_data_o(aes_data),
    .aes_result_i(aes_result), .aes_valid_i(aes_valid), .aes_ready_i(aes_ready)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, start_cnt = 0, start_cyc = 0, vrise_cyc = 0, wr_cyc = 0, eng_lat = 2;
  logic [1:0] start_op = '0;
  logic ready_en = 1'b1;

  logic [31:0]  model_key [4];
  logic [31:0]  model_data[4];
  logic [127:0] model_res = '0;
  logic [1:0]   model_op = '0;
  logic         model_err = 1'b0;

  // Stand-in for the engine: known FIPS-197 pairs, otherwise a reversible-looking mix
  function automatic logic [127:0] mock_aes(input logic [127:0] k, input logic [127:0] d,
                                            input logic [1:0] op);
    if (op == 2'd0 && k == FIPS_KEY && d == FIPS_PT) return FIPS_CT;
    if (op == 2'd1 && k == FIPS_KEY && d == FIPS_CT) return FIPS_PT;
    return {k[63:0] ^ d[127:64], d[63:0] + k[127:64]} ^ {126'd0, op};
  endfunction

  function automatic logic [127:0] key128();
    return {model_key[0], model_key[1], model_key[2], model_key[3]};
  endfunction

  function automatic logic [127:0] data128();
    return {model_data[0], model_data[1], model_data[2], model_data[3]};
  endfunction

  function automatic logic [31:0] st_word(input logic idle, input logic done, input logic err,
                                          input logic [1:0] op);
    return {27'd0, op, err, done, idle};
  endfunction

  function automatic logic [31:0] model_word(input logic [3:0] a);
    logic [127:0] r = model_res;
    if (a < 4'd4) return model_key[a[1:0]];
    if (a < 4'd8) return model_data[a[1:0]];
    if (a < 4'd12) return r[127 - 32*int'(a[1:0]) -: 32];
    return 32'd0;
  endfunction

  // Engine stub
  logic eng_busy = 1'b0;
  int   eng_cnt = 0;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      aes_valid  <= 1'b0;
      eng_busy   <= 1'b0;
      aes_result <= '0;
    end else if (aes_start) begin
      eng_busy   <= 1'b1;
      aes_valid  <= 1'b0;
      eng_cnt    <= eng_lat;
      aes_result <= mock_aes(aes_key, aes_data, aes_op);
    end else if (eng_busy) begin
      if (eng_cnt <= 1) begin
        aes_valid <= 1'b1;
        eng_busy  <= 1'b0;
        vrise_cyc <= cyc + 1;
      end else eng_cnt <= eng_cnt - 1;
    end
  end
  assign aes_ready = ready_en && !eng_busy;

  // Cycle index and start monitor (start_cyc = edge after which the pulse was visible)
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (aes_start) begin
      start_cnt = start_cnt + 1;
      start_cyc = cyc;
      start_op  = aes_op;
    end
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h exp %0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  // Bus tasks start and end at a negedge
  task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
    addr = a; wdata = d; we = 1'b1;
    @(negedge clk);
    wr_cyc = cyc;
    we = 1'b0;
  endtask

  task automatic bus_read(input logic [3:0] a, output logic [31:0] d);
    addr = a; re = 1'b1;
    @(negedge clk);
    re = 1'b0;
    chk("rvalid", 128'(rvalid), 128'(1));
    d = rdata;
  endtask

  task automatic bus_wr_rd(input logic [3:0] a, input logic [31:0] d, output logic [31:0] old);
    addr = a; wdata = d; we = 1'b1; re = 1'b1;
    @(negedge clk);
    we = 1'b0; re = 1'b0;
    old = rdata;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!irq && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("done_seen", 128'(irq), 128'(1));
    chk("done_cyc", 128'(cyc), 128'(vrise_cyc + 1));
  endtask

  task automatic check_result();
    logic [31:0] rd;
    for (int i = 0; i < 4; i++) begin
      bus_read(4'(8 + i), rd);
      chk("result", 128'(rd), 128'(model_res[127 - 32*i -: 32]));
    end
  endtask

  task automatic irq_ack();
    bus_write(A_CTRL, 32'h10);
    model_op = 2'd0;
    chk("irq_clr", 128'(irq), 128'(0));
  endtask

  // Ordinary key/data write; DATA3 may launch an operation in the auto-start build
  task automatic reg_write(input logic [3:0] a, input logic [31:0] d);
`ifdef AES128_AUTO_START_EN
    int s0 = start_cnt;
    int wcyc;
`endif
    bus_write(a, d);
    if (a < 4'd4) model_key[a[1:0]] = d;
    else if (a < 4'd8) model_data[a[1:0]] = d;
`ifdef AES128_AUTO_START_EN
    if (a == 4'd7) begin
      wcyc = wr_cyc;
      wait_done();
      chk("auto_start_cnt", 128'(start_cnt), 128'(s0 + 1));
      chk("auto_start_cyc", 128'(start_cyc), 128'(wcyc + 1));
      model_res = mock_aes(key128(), data128(), model_op);
      check_result();
      irq_ack();
    end
`endif
  endtask

  task automatic load_block(input logic [127:0] k, input logic [127:0] d);
    for (int i = 0; i < 4; i++) reg_write(4'(i), k[127 - 32*i -: 32]);
    for (int i = 0; i < 4; i++) reg_write(4'(4 + i), d[127 - 32*i -: 32]);
  endtask

  task automatic run_op(input logic [1:0] op, input int dly, input int lat);
    int s0, wcyc;
    logic [31:0] rd;
    eng_lat  = lat;
    ready_en = (dly == 0);
    s0 = start_cnt;
    bus_write(A_CTRL, {27'd0, 2'b00, op, 1'b1});
    model_op = op;
    wcyc = wr_cyc;
    if (dly > 0) begin
      repeat (dly - 1) @(negedge clk);
      bus_read(A_STATUS, rd);
      chk("pend_status", 128'(rd), 128'(st_word(1'b0, 1'b0, 1'b0, op)));
      chk("pend_nostart", 128'(start_cnt), 128'(s0));
      ready_en = 1'b1;
    end
    wait_done();
    chk("start_cnt", 128'(start_cnt), 128'(s0 + 1));
    chk("start_cyc", 128'(start_cyc), 128'(wcyc + dly + 1));
    chk("start_op", 128'(start_op), 128'(op));
    model_res = mock_aes(key128(), data128(), op);
    check_result();
    bus_read(A_STATUS, rd);
    chk("done_status", 128'(rd), 128'(st_word(1'b1, 1'b1, model_err, op)));
    bus_read(A_CYCLES, rd);
    chk("cycles", 128'(rd), 128'(vrise_cyc + 1 - wcyc));
    if (dly >= 20) chk("cycles_ge20", 128'(rd >= 32'd20), 128'(1));
    irq_ack();
  endtask

  initial begin
    logic [31:0] rd, d;
    logic [3:0]  a;
    int s0, n;
    for (int i = 0; i < 4; i++) begin
      model_key[i] = '0;
      model_data[i] = '0;
    end

    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk("rst_irq", 128'(irq), 128'(0));
    chk("rst_start", 128'(aes_start), 128'(0));
    chk("rst_op", 128'(aes_op), 128'(0));
    chk("rst_key", aes_key, 128'(0));
    chk("rst_data", aes_data, 128'(0));
    chk("rst_rdata", 128'(rdata), 128'(0));
    for (int i = 0; i < 15; i++) begin
      bus_read(4'(i), rd);
      chk("rst_read", 128'(rd), 128'((i == 13) ? 1 : 0));
    end

    // FIPS-197 encrypt, then decrypt of its ciphertext
    load_block(FIPS_KEY, FIPS_PT);
    run_op(2'd0, 0, 4);
    chk("fips_ct", model_res, FIPS_CT);
    load_block(FIPS_KEY, FIPS_CT);
    run_op(2'd1, 0, 5);
    chk("fips_pt", model_res, FIPS_PT);

    // Read-only and unmapped writes are ignored
    bus_write(4'd8, 32'hdeadbeef);
    bus_write(A_STATUS, 32'hffffffff);
    bus_write(4'd15, 32'h12345678);
    bus_read(4'd8, rd);
    chk("ro_result", 128'(rd), 128'(model_word(4'd8)));
    bus_read(4'd15, rd);
    chk("addr15", 128'(rd), 128'(0));

    // Start while busy: no second pulse, sticky err until CLR_ERR
    eng_lat = 10; ready_en = 1'b1; s0 = start_cnt;
    bus_write(A_CTRL, 32'h1); model_op = 2'd0;
    n = 0;
    while (start_cnt == s0 && n < 20) begin @(negedge clk); n++; end
    bus_write(A_CTRL, 32'h1); model_err = 1'b1;
    bus_read(A_STATUS, rd);
    chk("busy_err_status", 128'(rd), 128'(st_word(1'b0, 1'b0, 1'b1, 2'd0)));
    wait_done();
    chk("busy_one_start", 128'(start_cnt), 128'(s0 + 1));
    model_res = mock_aes(key128(), data128(), 2'd0);
    check_result();
    bus_read(A_STATUS, rd);
    chk("busy_done_status", 128'(rd), 128'(st_word(1'b1, 1'b1, 1'b1, 2'd0)));
    bus_write(A_CTRL, 32'h8); model_err = 1'b0;
    bus_read(A_STATUS, rd);
    chk("clr_err_status", 128'(rd), 128'(st_word(1'b1, 1'b1, 1'b0, 2'd0)));
    irq_ack();

    // Engine not ready for 20 cycles
    load_block({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    run_op(2'd1, 20, 3);

    // IRQ_ACK landing on the done-set edge loses to the set
    eng_lat = 3; ready_en = 1'b1;
    bus_write(A_CTRL, 32'h1); model_op = 2'd0;
    n = 0;
    while (!eng_busy && n < 20) begin @(negedge clk); n++; end
    n = 0;
    while (!aes_valid && n < 40) begin @(negedge clk); n++; end
    chk("race_pre_irq", 128'(irq), 128'(0));
    bus_write(A_CTRL, 32'h10); model_op = 2'd0;
    chk("race_irq_kept", 128'(irq), 128'(1));
    model_res = mock_aes(key128(), data128(), 2'd0);
    check_result();
    irq_ack();

    // DATA3 write: auto-start only when the build option is enabled
    d = $urandom;
`ifdef AES128_AUTO_START_EN
    reg_write(4'd7, d);
`else
    s0 = start_cnt;
    reg_write(4'd7, d);
    repeat (6) @(negedge clk);
    chk("data3_no_start", 128'(start_cnt), 128'(s0));
    chk("data3_no_irq", 128'(irq), 128'(0));
    bus_read(4'd7, rd);
    chk("data3_read", 128'(rd), 128'(d));
`endif

    // Randomized register traffic and operations
    for (int it = 0; it < 10; it++) begin
      repeat (3) begin
        a = 4'($urandom_range(0, 7));
        d = $urandom;
        if (a != 4'd7 && $urandom_range(0, 1) == 1) begin
          bus_wr_rd(a, d, rd);
          chk("rw_old", 128'(rd), 128'(model_word(a)));
          if (a < 4'd4) model_key[a[1:0]] = d;
          else model_data[a[1:0]] = d;
        end else reg_write(a, d);
      end
      a = 4'($urandom_range(0, 11));
      bus_read(a, rd);
      chk("reg_rd", 128'(rd), 128'(model_word(a)));
      run_op(2'($urandom_range(0, 3)), $urandom_range(0, 4), $urandom_range(1, 6));
    end

    // Reset in the middle of an operation
    eng_lat = 10; ready_en = 1'b1;
    bus_write(A_CTRL, 32'h1);
    n = 0;
    while (!eng_busy && n < 20) begin @(negedge clk); n++; end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_irq", 128'(irq), 128'(0));
    chk("mid_rst_key", aes_key, 128'(0));
    bus_read(A_STATUS, rd);
    chk("mid_rst_status", 128'(rd), 128'(1));
    bus_read(4'd8, rd);
    chk("mid_rst_result", 128'(rd), 128'(0));
    bus_read(A_CYCLES, rd);
    chk("mid_rst_cycles", 128'(rd), 128'(0));

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
